// File: rtl/def.sv
// Shared definitions for the ALU arbiter: funct3 operation encoding,
// funct7 qualifier constants and the requester index type.
package def;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SL   = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } f3OpInt;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam int N_REQ = 2;

  typedef logic req_id_t;

  function automatic logic [N_REQ-1:0] id_onehot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response bundle between two requesters, the arbiter and one consumer.
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// valid never waits on ready, and a held response stays stable until accepted.
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_op_imm;
  logic [1:0][2:0]        req_funct3;
  logic [1:0][6:0]        req_funct7;
  logic [1:0][31:0]       req_a;
  logic [1:0][31:0]       req_b;
  logic [1:0][TAG_W-1:0]  req_tag;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [TAG_W-1:0]       rsp_tag;
  logic [31:0]            rsp_t;
  logic                   rsp_illegal;

  modport master (
    output req_valid, req_op_imm, req_funct3, req_funct7, req_a, req_b, req_tag,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_tag, rsp_t, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op_imm, req_funct3, req_funct7, req_a, req_b, req_tag,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_tag, rsp_t, rsp_illegal
  );

endinterface

// File: rtl/alu_core.sv
// Combinational integer ALU. Undefined funct3/funct7 pairs flag illegal and
// return zero so the result is never X.
module alu_core
  import def::*;
(
  input  logic        op_imm,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] t,
  output logic        illegal
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    t       = '0;
    illegal = 1'b0;
    case (f3OpInt'(funct3))
      F3_ADD: begin
        // Immediate form has no SUB; funct7 bits there belong to the immediate.
        if (op_imm || funct7 == F7_BASE) t = a + b;
        else if (funct7 == F7_ALT)       t = a - b;
        else                             illegal = 1'b1;
      end
      F3_SL:   t = a << shamt;
      F3_SLT:  t = {31'b0, ($signed(a) < $signed(b))};
      F3_SLTU: t = {31'b0, (a < b)};
      F3_XOR:  t = a ^ b;
      F3_SR: begin
        if (funct7 == F7_BASE)     t = a >> shamt;
        else if (funct7 == F7_ALT) t = $unsigned($signed(a) >>> shamt);
        else                       illegal = 1'b1;
      end
      F3_OR:   t = a | b;
      F3_AND:  t = a & b;
      default: begin
        t       = '0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a single
// result register that can drain and refill in the same cycle.
module alu_arbiter
  import def::*;
#(
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output req_id_t      last_grant
);

  logic [1:0]       grant;
  req_id_t          gnt_id;
  logic             slot_free;
  logic             xfer;
  logic [31:0]      alu_t;
  logic             alu_illegal;

  logic             rsp_valid_q;
  req_id_t          rsp_id_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [31:0]      rsp_t_q;
  logic             rsp_illegal_q;
  req_id_t          last_grant_q;

  // Grant depends only on valids and the pointer, never on request data.
  always_comb begin
    grant  = 2'b00;
    gnt_id = 1'b0;
    case (bus.req_valid)
      2'b01: begin
        grant  = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        grant  = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        gnt_id = ~last_grant_q;
        grant  = id_onehot(~last_grant_q);
      end
      default: begin
        grant  = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

  assign slot_free     = !rsp_valid_q || bus.rsp_ready;
  assign bus.req_ready = (slot_free && !rst) ? grant : 2'b00;
  assign xfer          = |(bus.req_valid & bus.req_ready);

  alu_core u_alu (
    .op_imm  (bus.req_op_imm[gnt_id]),
    .funct3  (bus.req_funct3[gnt_id]),
    .funct7  (bus.req_funct7[gnt_id]),
    .a       (bus.req_a[gnt_id]),
    .b       (bus.req_b[gnt_id]),
    .t       (alu_t),
    .illegal (alu_illegal)
  );

  // Pointer moves only on a real transfer; a stalled grant leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_t_q       <= '0;
      rsp_illegal_q <= 1'b0;
      last_grant_q  <= 1'b1;
    end else if (xfer) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= gnt_id;
      rsp_tag_q     <= bus.req_tag[gnt_id];
      rsp_t_q       <= alu_t;
      rsp_illegal_q <= alu_illegal;
      last_grant_q  <= gnt_id;
    end else if (bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_t       = rsp_t_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign last_grant      = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the driver pushes hand-computed responses,
// the monitor pops and compares on every response transfer.
module tb_alu_arbiter;
  import def::*;

  localparam int TAG_W = 4;
  localparam int W     = 1 + TAG_W + 32 + 1;

  logic    clk = 1'b0;
  logic    rst;
  req_id_t last_grant;

  always #5 clk = ~clk;

  alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .last_grant (last_grant)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack_rsp(logic id, logic [TAG_W-1:0] tag,
                                            logic [31:0] t, logic ill);
    return {id, tag, t, ill};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic set_req(int i, logic imm, logic [2:0] f3, logic [6:0] f7,
                         logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag);
    bus.req_op_imm[i] = imm;
    bus.req_funct3[i] = f3;
    bus.req_funct7[i] = f7;
    bus.req_a[i]      = a;
    bus.req_b[i]      = b;
    bus.req_tag[i]    = tag;
  endtask

  // Called at a falling edge: apply valids, check the grant, advance one cycle.
  task automatic cycle(logic [1:0] valid, logic rdy, logic [1:0] exp_ready,
                       logic push_en, logic [W-1:0] exp_rsp);
    bus.req_valid = valid;
    bus.rsp_ready = rdy;
    #1;
    chk("req_ready", {62'b0, bus.req_ready}, {62'b0, exp_ready});
    if (push_en) exp_q.push_back(exp_rsp);
    @(negedge clk);
  endtask

  task automatic vec(logic id, logic imm, logic [2:0] f3, logic [6:0] f7,
                     logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag,
                     logic [31:0] exp_t, logic exp_ill);
    set_req(int'(id), imm, f3, f7, a, b, tag);
    cycle(id_onehot(id), 1'b1, id_onehot(id), 1'b1, pack_rsp(id, tag, exp_t, exp_ill));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_cleared(string name);
    chk({name, "_valid"},   {63'b0, bus.rsp_valid},   64'd0);
    chk({name, "_id"},      {63'b0, bus.rsp_id},      64'd0);
    chk({name, "_tag"},     {60'b0, bus.rsp_tag},     64'd0);
    chk({name, "_t"},       {32'b0, bus.rsp_t},       64'd0);
    chk({name, "_illegal"}, {63'b0, bus.rsp_illegal}, 64'd0);
    chk({name, "_last"},    {63'b0, last_grant},      64'd1);
  endtask

  // Monitor: a response moves on the next rising edge when valid & ready.
  initial begin
    logic [W-1:0] exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got %0h want none",
                   {bus.rsp_id, bus.rsp_tag, bus.rsp_t, bus.rsp_illegal});
        end else begin
          exp_v = exp_q.pop_front();
          chk("rsp", {26'b0, bus.rsp_id, bus.rsp_tag, bus.rsp_t, bus.rsp_illegal},
              {26'b0, exp_v});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0, 4'd0);

    // Reset: no accept while reset is high, result register cleared.
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("ready_in_reset", {62'b0, bus.req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    chk_cleared("reset");

    // Single ADD from requester 0.
    set_req(0, 1'b0, F3_ADD, F7_BASE, 32'd5, 32'd7, 4'd3);
    cycle(2'b01, 1'b1, 2'b01, 1'b1, pack_rsp(1'b0, 4'd3, 32'd12, 1'b0));
    cycle(2'b00, 1'b1, 2'b00, 1'b0, '0);

    // Both valid every cycle: alternate starting with requester 0.
    do_reset();
    set_req(0, 1'b0, F3_ADD, F7_BASE, 32'd1, 32'd2, 4'd1);
    set_req(1, 1'b0, F3_XOR, F7_BASE, 32'hF0, 32'hFF, 4'd2);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) cycle(2'b11, 1'b1, 2'b01, 1'b1, pack_rsp(1'b0, 4'd1, 32'd3, 1'b0));
      else            cycle(2'b11, 1'b1, 2'b10, 1'b1, pack_rsp(1'b1, 4'd2, 32'h0F, 1'b0));
    end
    cycle(2'b00, 1'b1, 2'b00, 1'b0, '0);

    // Operation vectors, back to back, including illegal encodings.
    vec(1'b1, 1'b0, F3_SR   == F3_SR ? F3_ADD : F3_ADD, F7_ALT, 32'h0, 32'h1, 4'd4, 32'hFFFF_FFFF, 1'b0);
    vec(1'b0, 1'b0, F3_SR,   F7_ALT,  32'h8000_0000, 32'd36, 4'd5, 32'hF800_0000, 1'b0);
    vec(1'b1, 1'b0, F3_SLT,  F7_BASE, 32'hFFFF_FFFF, 32'd1,  4'd6, 32'd1, 1'b0);
    vec(1'b0, 1'b0, F3_SLTU, F7_BASE, 32'hFFFF_FFFF, 32'd1,  4'd7, 32'd0, 1'b0);
    vec(1'b1, 1'b0, F3_SL,   F7_BASE, 32'h1,         32'd33, 4'd8, 32'h2, 1'b0);
    vec(1'b0, 1'b0, F3_SR,   F7_BASE, 32'h8000_0000, 32'd4,  4'd9, 32'h0800_0000, 1'b0);
    vec(1'b1, 1'b0, F3_AND,  F7_BASE, 32'hF0F0,      32'hFF00, 4'd10, 32'hF000, 1'b0);
    vec(1'b0, 1'b0, F3_OR,   F7_BASE, 32'hF0,        32'h0F, 4'd11, 32'hFF, 1'b0);
    vec(1'b1, 1'b1, F3_ADD,  7'h55,   32'hFFFF_FFFF, 32'd2,  4'd12, 32'd1, 1'b0);
    vec(1'b0, 1'b0, F3_ADD,  7'h01,   32'd5,         32'd7,  4'd13, 32'd0, 1'b1);
    vec(1'b1, 1'b0, F3_ADD,  F7_BASE, 32'd5,         32'd7,  4'd14, 32'd12, 1'b0);
    vec(1'b0, 1'b0, F3_SR,   7'h10,   32'hFFFF_0000, 32'd4,  4'd15, 32'd0, 1'b1);

    // Stall: result held, no grants, pointer frozen; then drain and accept together.
    set_req(0, 1'b0, F3_ADD, F7_BASE, 32'd10, 32'd20, 4'd5);
    cycle(2'b01, 1'b1, 2'b01, 1'b1, pack_rsp(1'b0, 4'd5, 32'd30, 1'b0));
    set_req(1, 1'b0, F3_XOR, F7_BASE, 32'hFF, 32'h0F, 4'd6);
    for (int k = 0; k < 3; k++) begin
      chk("hold_rsp", {26'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_t, bus.rsp_illegal},
          {26'b0, 1'b1, pack_rsp(1'b0, 4'd5, 32'd30, 1'b0)});
      chk("hold_last", {63'b0, last_grant}, 64'd0);
      cycle(2'b11, 1'b0, 2'b00, 1'b0, '0);
    end
    chk("hold_end_rsp", {26'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_t, bus.rsp_illegal},
        {26'b0, 1'b1, pack_rsp(1'b0, 4'd5, 32'd30, 1'b0)});
    cycle(2'b11, 1'b1, 2'b10, 1'b1, pack_rsp(1'b1, 4'd6, 32'hF0, 1'b0));
    cycle(2'b00, 1'b1, 2'b00, 1'b0, '0);

    // Reset while a result is held and stalled: discarded, fields cleared.
    set_req(0, 1'b0, F3_ADD, F7_BASE, 32'd1, 32'd1, 4'd7);
    cycle(2'b01, 1'b1, 2'b01, 1'b0, '0);
    chk("pre_reset_valid", {63'b0, bus.rsp_valid}, 64'd1);
    cycle(2'b00, 1'b0, 2'b00, 1'b0, '0);
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    #1;
    chk("ready_mid_reset", {62'b0, bus.req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("mid_reset");
    set_req(0, 1'b0, F3_ADD, F7_BASE, 32'd2, 32'd3, 4'd8);
    set_req(1, 1'b0, F3_XOR, F7_BASE, 32'h1, 32'h3, 4'd9);
    cycle(2'b11, 1'b1, 2'b01, 1'b1, pack_rsp(1'b0, 4'd8, 32'd5, 1'b0));
    cycle(2'b00, 1'b1, 2'b00, 1'b0, '0);
    cycle(2'b00, 1'b1, 2'b00, 1'b0, '0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TAG_W, 4, width of the per-request tag echoed with the result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid; index 0 = requester 0, index 1 = requester 1.
REQ-005 req_ready  output  2  per-requester accept; a request transfers when req_valid[i] & req_ready[i] at a clock edge.
REQ-006 req_op_imm  input  2  per-requester op_imm qualifier.
REQ-007 req_funct3  input  2x3  per-requester funct3 (f3OpInt encoding).
REQ-008 req_funct7  input  2x7  per-requester funct7.
REQ-009 req_a, req_b  input  2x32 each  per-requester operands.
REQ-010 req_tag  input  2xTAG_W  per-requester tag.
REQ-011 rsp_valid  output  1  result register holds a valid result.
REQ-012 rsp_ready  input  1  consumer accepts; result transfers when rsp_valid & rsp_ready.
REQ-013 rsp_id  output  1  requester index that issued the held result.
REQ-014 rsp_tag  output  TAG_W  tag of the held result.
REQ-015 rsp_t  output  32  held ALU result.
REQ-016 rsp_illegal  output  1  held request had an undefined funct3/funct7 combination.

Function
REQ-017 One shared ALU instance; at most one request granted per cycle.
REQ-018 Slot free = !rsp_valid | rsp_ready; req_ready[i] = slot free & grant[i]; no req_ready when slot not free.
REQ-019 Arbitration round-robin: one valid requester wins alone; both valid -> the requester not granted last wins.
REQ-020 last_grant pointer updates only on an actual transfer, never on a granted-but-stalled cycle.
REQ-021 Latency: request transferred at edge N -> rsp_valid=1 with its result from edge N, visible in cycle N+1.
REQ-022 Simultaneous drain and accept in one cycle SHALL sustain one result per cycle, no bubble.
REQ-023 Held result (rsp_id, rsp_tag, rsp_t, rsp_illegal) SHALL stay stable while rsp_valid & !rsp_ready.
REQ-024 Drain without new accept -> rsp_valid=0 next cycle; data fields retain last value.
REQ-025 Legal ops: ADD/SUB (funct7 0x00 or op_imm -> add; 0x20 -> sub), AND, OR, XOR, SL, SR (0x00 logical, 0x20 arithmetic), SLT signed, SLTU unsigned; 32-bit wraparound, no overflow flag.
REQ-026 Shift amounts use b[4:0] only.
REQ-027 Undefined combination (ADD reg form funct7 not 0x00/0x20, SR funct7 not 0x00/0x20) -> rsp_illegal=1, rsp_t=0; never X.
REQ-028 Starvation bound: a continuously valid requester transfers within 2 consecutive transfers.
REQ-029 req_ready SHALL not depend on the requester's own data fields, only on valids, pointer and slot state.

Reset
REQ-030 rst high at an edge -> rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_t=0, rsp_illegal=0, last_grant=1 (requester 0 wins first contention).
REQ-031 req_ready=0 while rst is high.
REQ-032 Reset mid-operation SHALL discard the held result without a transfer; no request is accepted in the reset cycle.

Structure
REQ-033 Shared package def.sv SHALL hold f3OpInt, funct7 constants F7_BASE=0x00 and F7_ALT=0x20, and requester-id typedef.
REQ-034 ALU SHALL be one sub-module, alu_core: combinational, inputs op_imm/funct3/funct7/a/b, outputs t and illegal.
REQ-035 Grant mux, round-robin pointer and result register live in alu_arbiter; no extra pipeline stages.

Verification
REQ-036 Reset, then req_valid=01, ADD a=5 b=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_t=12, rsp_id=0, rsp_tag=3.
REQ-037 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; first grant to 0; one result per cycle.
REQ-038 SUB funct7=0x20 a=0 b=1 -> rsp_t=0xFFFFFFFF; SR funct7=0x20 a=0x80000000 b=36 -> 0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0.
REQ-039 rsp_ready=0 for 3 cycles with result held -> req_ready=00, rsp fields stable, last_grant unchanged; rsp_ready=1 -> drain and accept same cycle.
REQ-040 ADD reg form funct7=0x01 -> rsp_illegal=1, rsp_t=0; next legal request -> rsp_illegal=0.
REQ-041 rst asserted while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, all rsp fields 0, first contention after reset granted to 0.
